// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - ID-stage hazard detection, stall/flush control and stall counter
module hazard_stall_controller (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  IFIDRs,
  input  logic [4:0]  IFIDRt,
  input  logic        IFIDUsesRt,
  input  logic        Branch,
  input  logic        BranchTaken,
  input  logic        Jump,
  input  logic        IDEXMemRead,
  input  logic        IDEXRegWrite,
  input  logic [4:0]  IDEXRd,
  input  logic        EXMEMMemRead,
  input  logic [4:0]  EXMEMRd,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush,
  output logic [15:0] StallCount
);

  // HOLD1 means one more forced stall cycle is owed (second cycle of a branch
  // waiting on a load that is still in EX).
  typedef enum logic {
    RUN   = 1'b0,
    HOLD1 = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic ex_match;
  logic mem_match;
  logic load_use;
  logic br_alu;
  logic br_load_ex;
  logic br_load_mem;
  logic stall;
  logic flush_cond;

  // A producer only matters if it writes a real register ($0 is hardwired)
  // that the ID instruction actually reads.
  function automatic logic src_match(input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  // Hazard terms against the EX- and MEM-stage producers.
  always_comb begin
    ex_match    = src_match(IDEXRd, IFIDRs, IFIDRt, IFIDUsesRt);
    mem_match   = src_match(EXMEMRd, IFIDRs, IFIDRt, IFIDUsesRt);
    load_use    = IDEXMemRead && ex_match;
    br_alu      = Branch && IDEXRegWrite && !IDEXMemRead && ex_match;
    br_load_ex  = Branch && IDEXMemRead && ex_match;
    br_load_mem = Branch && EXMEMMemRead && mem_match;
    flush_cond  = (Branch && BranchTaken) || Jump;
  end

  // Next state and pipeline controls; reset forces the free-running values.
  always_comb begin
    state_nxt  = RUN;
    stall      = 1'b0;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    if (Rst) begin
      case (state)
        RUN: begin
          stall     = load_use || br_alu || br_load_ex || br_load_mem;
          state_nxt = br_load_ex ? HOLD1 : RUN;
        end
        HOLD1: begin
          stall     = 1'b1;
          state_nxt = RUN;
        end
        default: begin
          stall     = 1'b0;
          state_nxt = RUN;
        end
      endcase
      PCWrite    = !stall;
      IFIDWrite  = !stall;
      IDEXBubble = stall;
      // A stalled branch is re-examined once it is released, so no flush now.
      IFIDFlush  = !stall && flush_cond;
    end
  end

  // State register; reset drops any owed stall cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      StallCount <= 16'd0;
    end else if (stall && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - table, sequence and random checks of hazard_stall_controller
module tb_hazard_stall_controller;

  logic        Clk;
  logic        Rst;
  logic [4:0]  IFIDRs;
  logic [4:0]  IFIDRt;
  logic        IFIDUsesRt;
  logic        Branch;
  logic        BranchTaken;
  logic        Jump;
  logic        IDEXMemRead;
  logic        IDEXRegWrite;
  logic [4:0]  IDEXRd;
  logic        EXMEMMemRead;
  logic [4:0]  EXMEMRd;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXBubble;
  logic        IFIDFlush;
  logic [15:0] StallCount;

  hazard_stall_controller dut (
    .Clk(Clk), .Rst(Rst), .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDUsesRt(IFIDUsesRt),
    .Branch(Branch), .BranchTaken(BranchTaken), .Jump(Jump),
    .IDEXMemRead(IDEXMemRead), .IDEXRegWrite(IDEXRegWrite), .IDEXRd(IDEXRd),
    .EXMEMMemRead(EXMEMMemRead), .EXMEMRd(EXMEMRd),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
    .IFIDFlush(IFIDFlush), .StallCount(StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesrt;
    logic       branch;
    logic       taken;
    logic       jump;
    logic       idexmr;
    logic       idexrw;
    logic [4:0] idexrd;
    logic       exmemmr;
    logic [4:0] exmemrd;
  } in_t;

  // exp = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}
  typedef struct {
    in_t        i;
    logic [3:0] exp;
  } vec_t;

  localparam logic [3:0] GO    = 4'b1100;
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1101;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: number of stall cycles still owed and the expected count.
  int owed = 0;
  int cnt  = 0;

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic usesrt,
                             input logic branch, input logic taken, input logic jump,
                             input logic idexmr, input logic idexrw, input logic [4:0] idexrd,
                             input logic exmemmr, input logic [4:0] exmemrd);
    in_t x;
    x.rst = 1'b1; x.rs = rs; x.rt = rt; x.usesrt = usesrt;
    x.branch = branch; x.taken = taken; x.jump = jump;
    x.idexmr = idexmr; x.idexrw = idexrw; x.idexrd = idexrd;
    x.exmemmr = exmemmr; x.exmemrd = exmemrd;
    return x;
  endfunction

  function automatic in_t quiet();
    return mk(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd4);
  endfunction

  // How many stall cycles the ID instruction must wait, from the pipeline rules.
  function automatic int cost_of(input in_t x);
    bit reads_ex, reads_mem;
    reads_ex  = (x.idexrd != 0) && (x.idexrd == x.rs || (x.usesrt && x.idexrd == x.rt));
    reads_mem = (x.exmemrd != 0) && (x.exmemrd == x.rs || (x.usesrt && x.exmemrd == x.rt));
    if (x.branch && x.idexmr && reads_ex) return 2;
    if (x.idexmr && reads_ex) return 1;
    if (x.branch && x.idexrw && reads_ex) return 1;
    if (x.branch && x.exmemmr && reads_mem) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check combinational outputs against the model (and the
  // table value if given), clock, then check the counter.
  task automatic step(input in_t x, input logic use_tab, input logic [3:0] tab_exp);
    logic [3:0] got, mexp;
    bit st;
    int c;
    Rst = x.rst; IFIDRs = x.rs; IFIDRt = x.rt; IFIDUsesRt = x.usesrt;
    Branch = x.branch; BranchTaken = x.taken; Jump = x.jump;
    IDEXMemRead = x.idexmr; IDEXRegWrite = x.idexrw; IDEXRd = x.idexrd;
    EXMEMMemRead = x.exmemmr; EXMEMRd = x.exmemrd;
    #2;
    c = cost_of(x);
    st = x.rst && (owed > 0 || c > 0);
    if (st) mexp = STALL;
    else if (x.rst && ((x.branch && x.taken) || x.jump)) mexp = FLUSH;
    else mexp = GO;
    got = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush};
    chk("ctrl_model", {12'd0, got}, {12'd0, mexp});
    if (use_tab) chk("ctrl_table", {12'd0, got}, {12'd0, tab_exp});
    @(posedge Clk);
    #1;
    if (!x.rst) begin
      owed = 0;
      cnt  = 0;
    end else if (st) begin
      cnt  = (cnt < 65535) ? cnt + 1 : 65535;
      owed = (owed > 0) ? owed - 1 : c - 1;
    end
    chk("stall_count", StallCount, cnt[15:0]);
  endtask

  task automatic do_reset();
    in_t r;
    r = quiet();
    r.rst = 1'b0;
    step(r, 1'b1, GO);
  endtask

  vec_t tab[15];
  in_t  x;

  initial begin
    Rst = 1'b0; IFIDRs = 0; IFIDRt = 0; IFIDUsesRt = 0; Branch = 0; BranchTaken = 0;
    Jump = 0; IDEXMemRead = 0; IDEXRegWrite = 0; IDEXRd = 0; EXMEMMemRead = 0; EXMEMRd = 0;
    @(posedge Clk);
    #1;
    do_reset();
    chk("reset_count", StallCount, 16'd0);

    //              rs  rt  ur br tk jp mr rw idexrd mmr exmemrd
    tab[0]  = '{i: mk(1,  2,  1, 0, 0, 0, 0, 0, 3,  0, 4),  exp: GO};
    tab[1]  = '{i: mk(8,  10, 1, 0, 0, 0, 1, 1, 8,  0, 0),  exp: STALL};
    tab[2]  = '{i: mk(10, 8,  1, 0, 0, 0, 1, 1, 8,  0, 0),  exp: STALL};
    tab[3]  = '{i: mk(10, 7,  0, 0, 0, 0, 1, 1, 7,  0, 0),  exp: GO};
    tab[4]  = '{i: mk(0,  0,  1, 1, 0, 0, 1, 1, 0,  1, 0),  exp: GO};
    tab[5]  = '{i: mk(5,  0,  1, 1, 1, 0, 0, 1, 5,  0, 0),  exp: STALL};
    tab[6]  = '{i: mk(5,  6,  1, 0, 0, 0, 0, 1, 5,  0, 0),  exp: GO};
    tab[7]  = '{i: mk(5,  6,  1, 1, 1, 0, 0, 0, 5,  0, 0),  exp: FLUSH};
    tab[8]  = '{i: mk(1,  2,  1, 0, 0, 1, 0, 0, 3,  0, 4),  exp: FLUSH};
    tab[9]  = '{i: mk(1,  2,  1, 1, 0, 0, 0, 0, 3,  0, 4),  exp: GO};
    tab[10] = '{i: mk(1,  9,  1, 1, 0, 0, 0, 0, 3,  1, 9),  exp: STALL};
    tab[11] = '{i: mk(1,  9,  1, 0, 0, 0, 0, 0, 3,  1, 9),  exp: GO};
    tab[12] = '{i: mk(8,  9,  1, 1, 1, 0, 1, 0, 8,  0, 0),  exp: STALL};
    tab[13] = '{i: mk(8,  9,  1, 1, 1, 0, 1, 0, 8,  0, 0),  exp: GO};
    tab[13].i.rst = 1'b0;
    tab[14] = '{i: mk(0,  0,  1, 1, 1, 1, 1, 1, 0,  1, 0),  exp: FLUSH};
    for (int k = 0; k < 15; k++) begin
      step(tab[k].i, 1'b1, tab[k].exp);
      step(quiet(), 1'b0, GO);
      step(quiet(), 1'b1, GO);
    end

    // Load-use: one stall, counter 0 -> 1.
    do_reset();
    step(mk(8, 10, 1, 0, 0, 0, 1, 1, 8, 0, 0), 1'b1, STALL);
    chk("lu_count", StallCount, 16'd1);
    step(mk(8, 10, 1, 0, 0, 0, 0, 0, 0, 1, 8), 1'b1, GO);
    chk("lu_count_after", StallCount, 16'd1);

    // Branch on a load in EX: two stalls, then the taken branch flushes once.
    do_reset();
    step(mk(8, 9, 1, 1, 1, 0, 1, 1, 8, 0, 0), 1'b1, STALL);
    step(mk(8, 9, 1, 1, 1, 0, 0, 0, 0, 1, 8), 1'b1, STALL);
    step(mk(8, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1'b1, FLUSH);
    chk("brld_count", StallCount, 16'd2);
    step(quiet(), 1'b1, GO);

    // Branch on an ALU result: one stall, then flush follows BranchTaken.
    do_reset();
    step(mk(5, 0, 1, 1, 0, 0, 0, 1, 5, 0, 0), 1'b1, STALL);
    step(mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, GO);
    chk("bralu_count", StallCount, 16'd1);
    do_reset();
    step(mk(5, 0, 1, 1, 1, 0, 0, 1, 5, 0, 0), 1'b1, STALL);
    step(mk(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 1'b1, FLUSH);

    // Reset while a second stall cycle is owed cancels it.
    do_reset();
    step(mk(8, 9, 1, 1, 0, 0, 1, 0, 8, 0, 0), 1'b1, STALL);
    x = mk(8, 9, 1, 1, 0, 0, 0, 0, 0, 1, 8);
    x.rst = 1'b0;
    step(x, 1'b1, GO);
    chk("rst_mid_count", StallCount, 16'd0);
    step(quiet(), 1'b1, GO);

    // Random traffic against the model, small register range to provoke matches.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      x = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 5'($urandom_range(0, 3)));
      x.rst = ($urandom_range(0, 49) != 0);
      step(x, 1'b0, GO);
    end

    // Saturation: 65535 stalls reach FFFF, one more must not wrap.
    do_reset();
    for (int k = 0; k < 65535; k++) begin
      step(mk(8, 10, 1, 0, 0, 0, 1, 1, 8, 0, 0), 1'b0, GO);
    end
    chk("sat_reach", StallCount, 16'hFFFF);
    step(mk(8, 10, 1, 0, 0, 0, 1, 1, 8, 0, 0), 1'b1, STALL);
    chk("sat_hold", StallCount, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-002 Rst  in  1  synchronous, active-low reset, sampled on the Clk rising edge.
REQ-003 IFIDRs, IFIDRt  in  5 each  source registers of the instruction in ID.
REQ-004 IFIDUsesRt  in  1  1 = the ID instruction reads Rt (R-type, beq, bne, sw).
REQ-005 Branch  in  1  1 = the ID instruction is a conditional branch resolved in ID.
REQ-006 BranchTaken  in  1  ID-stage compare result; valid only when Branch=1.
REQ-007 Jump  in  1  1 = the ID instruction is j, jal or jr.
REQ-008 IDEXMemRead, IDEXRegWrite  in  1 each  control bits of the EX-stage instruction.
REQ-009 IDEXRd  in  5  resolved destination of the EX-stage instruction.
REQ-010 EXMEMMemRead  in  1  the MEM-stage instruction is a load.
REQ-011 EXMEMRd  in  5  destination of the MEM-stage instruction.
REQ-012 PCWrite  out  1  1 = PC may update.
REQ-013 IFIDWrite  out  1  1 = the IF/ID register may load.
REQ-014 IDEXBubble  out  1  1 = zero all ID/EX control bits this cycle.
REQ-015 IFIDFlush  out  1  1 = replace the IF/ID contents with a nop at the next edge.
REQ-016 StallCount  out  16  count of stall cycles, saturating.

Function
REQ-017 The block SHALL have two states: RUN and HOLD1 (one forced stall cycle still owed).
REQ-018 Each match term SHALL require the destination to be nonzero and equal to IFIDRs, or equal to IFIDRt with IFIDUsesRt=1.
REQ-019 LoadUse: in RUN, the block SHALL detect IDEXMemRead=1 with IDEXRd matching.
REQ-020 BrAlu: in RUN, the block SHALL detect Branch=1, IDEXRegWrite=1, IDEXMemRead=0 and IDEXRd matching.
REQ-021 BrLoadEX: in RUN, the block SHALL detect Branch=1, IDEXMemRead=1 and IDEXRd matching.
REQ-022 BrLoadMEM: in RUN, the block SHALL detect Branch=1, EXMEMMemRead=1 and EXMEMRd matching.
REQ-023 Stall is asserted when any of REQ-019 to REQ-022 holds in RUN, or unconditionally in HOLD1; it SHALL drive PCWrite=0, IFIDWrite=0, IDEXBubble=1 combinationally in the same cycle (zero latency).
REQ-024 With no stall, outputs SHALL be PCWrite=1, IFIDWrite=1, IDEXBubble=0.
REQ-025 RUN SHALL go to HOLD1 only on BrLoadEX; HOLD1 SHALL always return to RUN after one cycle, so BrLoadEX costs exactly 2 stall cycles.
REQ-026 LoadUse, BrAlu and BrLoadMEM SHALL cost exactly 1 stall cycle each and SHALL leave the state in RUN.
REQ-027 In HOLD1, the detection terms SHALL be ignored.
REQ-028 IFIDFlush SHALL be 1 when stall is 0 and either (Branch=1 and BranchTaken=1) or Jump=1; otherwise IFIDFlush SHALL be 0.
REQ-029 When stall and a flush condition occur together, stall SHALL win, IFIDFlush=0, and the flush is re-evaluated when the branch leaves the stall.
REQ-030 StallCount SHALL increment by 1 at each edge where stall=1, and SHALL hold at 16'hFFFF with no wrap.
REQ-031 Register $0 SHALL never cause a stall, whatever the control bits are.

Reset
REQ-032 With Rst=0 at an edge, the state SHALL become RUN and StallCount SHALL become 0.
REQ-033 While Rst=0, the outputs SHALL be forced to PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.
REQ-034 A reset during HOLD1 SHALL cancel the owed stall; the first cycle after reset SHALL evaluate in RUN.

Verification
REQ-035 Load-use: lw $8 in EX (IDEXMemRead=1, IDEXRd=8), add $9,$8,$10 in ID -> exactly one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1; StallCount 0->1.
REQ-036 Branch after load: lw $8 in EX, beq $8,$9 in ID with Branch=1 -> stall for 2 consecutive cycles (RUN->HOLD1->RUN); then BranchTaken=1 -> IFIDFlush=1 for one cycle; StallCount=2.
REQ-037 Branch after ALU op: add $5 in EX (IDEXRegWrite=1, IDEXRd=5), bne $5,$0 in ID -> 1 stall cycle; next cycle no stall; IFIDFlush follows BranchTaken.
REQ-038 Zero register: IDEXMemRead=1, IDEXRd=0, IFIDRs=0 -> no stall; also IFIDUsesRt=0 with IFIDRt=IDEXRd=7 -> no stall.
REQ-039 Reset mid-stall: enter HOLD1 via BrLoadEX, drive Rst=0 at the next edge -> state RUN, StallCount=0, PCWrite=1 during reset.
REQ-040 Saturation: preload via 65535 stall cycles, apply one more stall -> StallCount stays 16'hFFFF.
